mux41_rr_arbiter: RTL and testbench
===================================

Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 4-bit 4:1 mux datapath (`sel`, `a`..`d`, `y`).
- Shares one downstream 4-bit channel between four requesters with a req/ack handshake.
- Grants bursts of up to BURST beats per owner and drives the mux `sel` from a register.
- Sits between four producer blocks and a single consumer with a valid/ready input.

Parameters:
- DW, 4, data width of each requester port and of `y`.
- BURST, 4, maximum accepted beats per grant (1..15); the beat counter is 4 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  per-requester "data valid"; bit i qualifies port i.
- a  in  DW  requester 0 data.
- b  in  DW  requester 1 data.
- c  in  DW  requester 2 data.
- d  in  DW  requester 3 data.
- out_ready  in  1  consumer accepts `y` this cycle.
- sel  out  2  registered mux select (index of current owner).
- gnt  out  4  registered one-hot grant; all zero when idle.
- y  out  DW  combinational mux of a/b/c/d by `sel`.
- out_valid  out  1  `y` is valid this cycle.
- ack  out  4  combinational per-port accept strobe.
- busy  out  1  high while a grant is held.

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - state=IDLE, sel=0, gnt=0, busy=0, out_valid=0, ack=0.
  - beat counter=0; round-robin pointer ptr=3, so port 0 has top priority first.
  - `y` equals `a` during reset because sel=0.
- States are IDLE and OWN.
- IDLE:
  - gnt=0, out_valid=0, ack=0.
  - At an edge with req!=0: winner = first set req bit in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Then go to OWN with sel=winner, gnt=onehot(winner), beat=0.
  - Arbitration latency is exactly one cycle from req rising to out_valid.
- OWN, combinational outputs:
  - out_valid = req[sel].
  - ack[sel] = req[sel] & out_ready; other ack bits are 0.
  - accept = ack[sel].
- OWN, at each edge:
  - If accept, beat <= beat+1.
  - release = (accept && beat==BURST-1) || !req[sel].
  - On release, ptr <= sel. If any req bit is set, re-pick using the IDLE priority order from the new ptr, stay in OWN, load sel/gnt, and reset beat=0. This handoff has zero bubble.
  - If no req bit is set on release, go to IDLE.
  - The current owner is lowest priority on release. It is re-granted only if no other port requests.
- Stall: with req[sel]=1 and out_ready=0, sel, gnt, beat and out_valid all hold. A stall never releases the grant.
- Requester protocol:
  - A requester holds `req` and its data stable until it sees ack.
  - After ack it may present the next word or drop req.
  - Dropping req while owning releases the grant at the next edge, with no beat counted.
- Data is never registered in this block, so `y` changes in the same cycle as `sel`.
- Fairness: a continuously requesting port is granted within 3*BURST accepted beats of other owners.
- Simultaneous events: a new req arriving on the release edge is considered in that same pick.
- Reset mid-burst returns all outputs to reset values immediately, with no ack.

Decomposition:
- Shared defines file `mux41_arb_defs.vh` holds:
  - NPORT=4 and SEL_W=2.
  - State encodings ST_IDLE=1'b0 and ST_OWN=1'b1.
  - BEAT_W=4.
- Sub-module `rr_pick4`: combinational. Inputs req[3:0] and ptr[1:0]; outputs any and idx[1:0]. It is used for both the IDLE pick and the release pick.
- The mux itself is an internal always/case on `sel`.

Test Plan:
- Reset: assert rst mid-OWN with out_ready=1 → sel=0, gnt=0000, out_valid=0, ack=0000 immediately. After release, req=0001 gives gnt=0001 one cycle later.
- Single burst, BURST=4: req=0001, out_ready=1, `a` stepping 1,2,3,4,5 → four acks carrying y=1..4. Release at the 4th ack, then a new burst to port 0 with beat=0.
- Round-robin: req=1111 held, out_ready=1, BURST=2 → owners 0,0,1,1,2,2,3,3,0 with no bubble between owners.
- Stall: port 2 owns, out_ready=0 for 5 cycles → out_valid=1, ack=0000, y=c stable, beat unchanged. Raising out_ready gives ack=0100.
- Early drop: port 1 owns, drops req after 1 beat while req[3]=1 → next edge sel=3, gnt=1000, ptr=1.
- Idle return: only the owner requests, then drops req → IDLE the next cycle, out_valid=0, busy=0.

Source files
------------

// File: rtl/mux41_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin 4:1 mux arbiter.
// Port count, select/beat widths, FSM states and a one-hot helper.
package mux41_rr_arbiter_pkg;

  localparam int NPORT  = 4;
  localparam int SEL_W  = 2;
  localparam int BEAT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  function automatic logic [NPORT-1:0] onehot(
    input logic [SEL_W-1:0] i
  );
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// Rotating-priority picker: first set req bit after ptr,
// searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4
  import mux41_rr_arbiter_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_cand;

  // Scan lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    any    = |req;
    idx    = ptr;
    w_cand = ptr;
    for (int k = NPORT; k >= 1; k--) begin
      w_cand = ptr + SEL_W'(k);
      if (req[w_cand]) idx = w_cand;
    end
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin burst arbiter sharing one channel between four requesters.
// Registered sel/gnt; y, ack and out_valid follow combinationally.
module mux41_rr_arbiter
  import mux41_rr_arbiter_pkg::*;
#(
  parameter int DW    = 4,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [DW-1:0]    c,
  input  logic [DW-1:0]    d,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [NPORT-1:0] gnt,
  output logic [DW-1:0]    y,
  output logic             out_valid,
  output logic [NPORT-1:0] ack,
  output logic             busy
);

  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BURST - 1);

  state_t           r_state;
  state_t           w_next;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [NPORT-1:0] r_gnt;
  logic [BEAT_W-1:0] r_beat;

  logic             w_own;
  logic             w_req_sel;
  logic             w_accept;
  logic             w_release;
  logic             w_any;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_pick_ptr;

  assign sel = r_sel;
  assign gnt = r_gnt;

  assign w_own     = (r_state == ST_OWN);
  assign w_req_sel = req[r_sel];
  assign w_accept  = w_own & w_req_sel & out_ready;
  assign w_release = w_own &
                     ((w_accept & (r_beat == LAST)) | ~w_req_sel);

  // On release the owner becomes lowest priority for the re-pick.
  assign w_pick_ptr = w_release ? r_sel : r_ptr;

  rr_pick4 u_pick (
    .req (req),
    .ptr (w_pick_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state: grab on any request, drop to idle when nobody is left.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_next = ST_OWN;
      ST_OWN:  if (w_release && !w_any) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Owner, grant, beat counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel  <= '0;
      r_gnt  <= '0;
      r_beat <= '0;
      r_ptr  <= SEL_W'(NPORT - 1);
    end else if (!w_own) begin
      if (w_any) begin
        r_sel  <= w_idx;
        r_gnt  <= onehot(w_idx);
        r_beat <= '0;
      end
    end else if (w_release) begin
      r_ptr  <= r_sel;
      r_beat <= '0;
      if (w_any) begin
        r_sel <= w_idx;
        r_gnt <= onehot(w_idx);
      end else begin
        r_gnt <= '0;
      end
    end else if (w_accept) begin
      r_beat <= r_beat + BEAT_W'(1);
    end
  end

  // Handshake outputs derived from the current owner.
  always_comb begin
    out_valid = w_own & w_req_sel;
    busy      = w_own;
    ack       = '0;
    if (w_accept) ack[r_sel] = 1'b1;
  end

  // Unregistered data mux so y tracks sel in the same cycle.
  always_comb begin
    case (r_sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter.
// u1 uses BURST=4, u2 uses BURST=2; both share stimulus.
module tb_mux41_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] a = '0, b = '0, c = '0, d = '0;
  logic       out_ready = 1'b0;

  logic [1:0] sel1, sel2;
  logic [3:0] gnt1, gnt2, y1, y2, ack1, ack2;
  logic       ov1, ov2, busy1, busy2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux41_rr_arbiter #(.DW(4), .BURST(4)) u1 (
    .clk(clk), .rst(rst), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready),
    .sel(sel1), .gnt(gnt1), .y(y1),
    .out_valid(ov1), .ack(ack1), .busy(busy1)
  );

  mux41_rr_arbiter #(.DW(4), .BURST(2)) u2 (
    .clk(clk), .rst(rst), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready),
    .sel(sel2), .gnt(gnt2), .y(y2),
    .out_valid(ov2), .ack(ack2), .busy(busy2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; a = 4'd5; req = '0;
    tick();
    #1;
    checks++;
    if ({sel1, gnt1, busy1, ov1, ack1} !== 12'h0) begin
      failures++;
      $display("FAIL reset_state sel=%0d gnt=%b busy=%b ov=%b ack=%b exp all 0",
               sel1, gnt1, busy1, ov1, ack1);
    end
    checks++;
    if (y1 !== 4'd5) begin
      failures++;
      $display("FAIL reset_y got=%0d exp=5", y1);
    end
    rst = 1'b0; req = 4'b0001; out_ready = 1'b1;
    tick();
    checks++;
    if (gnt1 !== 4'b0001 || ov1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_own gnt=%b ov=%b exp 0001/1", gnt1, ov1);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sel1, gnt1, busy1, ov1, ack1} !== 12'h0) begin
      failures++;
      $display("FAIL reset_mid_own sel=%0d gnt=%b busy=%b ov=%b ack=%b exp all 0",
               sel1, gnt1, busy1, ov1, ack1);
    end
    #1 rst = 1'b0;
    tick();
    checks++;
    if (gnt1 !== 4'b0001 || sel1 !== 2'd0) begin
      failures++;
      $display("FAIL reset_regrant gnt=%b sel=%0d exp 0001/0", gnt1, sel1);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_single_burst;
    do_reset();
    req = 4'b0001; out_ready = 1'b1; a = 4'd1;
    #1;
    checks++;
    if (gnt1 !== 4'b0000 || ov1 !== 1'b0 || ack1 !== 4'b0000) begin
      failures++;
      $display("FAIL burst_idle gnt=%b ov=%b ack=%b exp 0000/0/0000",
               gnt1, ov1, ack1);
    end
    tick();
    for (int i = 1; i <= 8; i++) begin
      a = 4'(i);
      if (i == 7) begin
        req = 4'b0101;
        c = 4'd9;
      end
      #1;
      checks++;
      if (gnt1 !== 4'b0001 || ack1 !== 4'b0001 || y1 !== 4'(i)) begin
        failures++;
        $display("FAIL burst_beat%0d gnt=%b ack=%b y=%0d exp 0001/0001/%0d",
                 i, gnt1, ack1, y1, i);
      end
      tick();
    end
    #1;
    checks++;
    if (gnt1 !== 4'b0100 || ack1 !== 4'b0100 || y1 !== 4'd9) begin
      failures++;
      $display("FAIL burst_handoff gnt=%b ack=%b y=%0d exp 0100/0100/9",
               gnt1, ack1, y1);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_own [9];
    logic [3:0] exp_oh;
    exp_own = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2,
                2'd2, 2'd3, 2'd3, 2'd0};
    do_reset();
    a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
    req = 4'b1111; out_ready = 1'b1;
    #1;
    checks++;
    if (ov2 !== 1'b0 || gnt2 !== 4'b0000) begin
      failures++;
      $display("FAIL rr_idle ov=%b gnt=%b exp 0/0000", ov2, gnt2);
    end
    tick();
    for (int i = 0; i < 9; i++) begin
      exp_oh = 4'b0001 << exp_own[i];
      #1;
      checks++;
      if (sel2 !== exp_own[i] || gnt2 !== exp_oh || ack2 !== exp_oh ||
          ov2 !== 1'b1 || y2 !== ({2'b00, exp_own[i]} + 4'd1)) begin
        failures++;
        $display("FAIL rr_cycle%0d sel=%0d gnt=%b ack=%b ov=%b y=%0d exp sel=%0d",
                 i, sel2, gnt2, ack2, ov2, y2, exp_own[i]);
      end
      tick();
    end
  endtask

  task automatic test_stall;
    do_reset();
    req = 4'b0100; c = 4'd7; d = 4'd8; out_ready = 1'b0;
    tick();
    req = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (ov1 !== 1'b1 || ack1 !== 4'b0000 || y1 !== 4'd7 ||
          gnt1 !== 4'b0100) begin
        failures++;
        $display("FAIL stall%0d ov=%b ack=%b y=%0d gnt=%b exp 1/0000/7/0100",
                 i, ov1, ack1, y1, gnt1);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ack1 !== 4'b0100 || gnt1 !== 4'b0100) begin
        failures++;
        $display("FAIL stall_resume%0d ack=%b gnt=%b exp 0100/0100",
                 i, ack1, gnt1);
      end
      tick();
    end
    #1;
    checks++;
    if (gnt1 !== 4'b1000 || ack1 !== 4'b1000 || y1 !== 4'd8) begin
      failures++;
      $display("FAIL stall_next gnt=%b ack=%b y=%0d exp 1000/1000/8",
               gnt1, ack1, y1);
    end
  endtask

  task automatic test_early_drop;
    do_reset();
    req = 4'b0010; b = 4'd3; d = 4'd6; out_ready = 1'b1;
    tick();
    req = 4'b1010;
    #1;
    checks++;
    if (sel1 !== 2'd1 || ack1 !== 4'b0010 || y1 !== 4'd3) begin
      failures++;
      $display("FAIL drop_own sel=%0d ack=%b y=%0d exp 1/0010/3",
               sel1, ack1, y1);
    end
    tick();
    req = 4'b1001;
    #1;
    checks++;
    if (ov1 !== 1'b0 || ack1 !== 4'b0000 || gnt1 !== 4'b0010) begin
      failures++;
      $display("FAIL drop_cycle ov=%b ack=%b gnt=%b exp 0/0000/0010",
               ov1, ack1, gnt1);
    end
    tick();
    checks++;
    if (sel1 !== 2'd3 || gnt1 !== 4'b1000 || ack1 !== 4'b1000 ||
        y1 !== 4'd6) begin
      failures++;
      $display("FAIL drop_handoff sel=%0d gnt=%b ack=%b y=%0d exp 3/1000/1000/6",
               sel1, gnt1, ack1, y1);
    end
  endtask

  task automatic test_idle_return;
    do_reset();
    req = 4'b0001; a = 4'd2; out_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (busy1 !== 1'b1 || ack1 !== 4'b0001) begin
      failures++;
      $display("FAIL idle_own busy=%b ack=%b exp 1/0001", busy1, ack1);
    end
    tick();
    req = 4'b0000;
    #1;
    checks++;
    if (ov1 !== 1'b0 || ack1 !== 4'b0000 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL idle_drop ov=%b ack=%b busy=%b exp 0/0000/1",
               ov1, ack1, busy1);
    end
    tick();
    checks++;
    if (busy1 !== 1'b0 || ov1 !== 1'b0 || gnt1 !== 4'b0000) begin
      failures++;
      $display("FAIL idle_back busy=%b ov=%b gnt=%b exp 0/0/0000",
               busy1, ov1, gnt1);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_stall();
    test_early_drop();
    test_idle_return();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
